// File: rtl/frame_diff_pkg.sv
// Shared definitions for the frame-difference binarizer: default widths,
// pipeline latency and the statistics FSM state encoding.
package frame_diff_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 20;

    // Data and sync signals leave the block this many clocks after entering.
    localparam int PIPE_LAT = 3;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } stats_state_t;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

endpackage

// File: rtl/frame_diff_stats.sv
// Per-frame changed-pixel statistics: saturating accumulator, frame FSM
// and the diff_count / motion_flag / frame_done output registers.
module frame_diff_stats
    import frame_diff_pkg::*;
#(
    parameter int              CNT_W      = CNT_W_DEF,
    parameter logic [CNT_W-1:0] MOTION_MIN = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vsync_in,
    input  logic             i_vs2,
    input  logic             i_bit2,
    output logic [CNT_W-1:0] o_diff_count,
    output logic             o_motion_flag,
    output logic             o_frame_done
);

    stats_state_t     r_state;
    stats_state_t     w_next_state;
    logic             r_armed;
    logic             r_arm1;
    logic             r_arm2;
    logic             r_vs_eff_d;
    logic             w_vs_eff;
    logic             w_rise;
    logic             w_fall;
    logic             w_acc_load;
    logic             w_acc_inc;
    logic             w_capture;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_diff_count;
    logic             r_motion_flag;
    logic             r_frame_done;

    // A frame only counts once vsync has been seen low after reset; the armed
    // bit travels alongside vsync so it lines up with the S2 copy.
    assign w_vs_eff = i_vs2 & r_arm2;
    assign w_rise   = w_vs_eff & ~r_vs_eff_d;
    assign w_fall   = ~w_vs_eff & r_vs_eff_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_SOF: if (w_rise) w_next_state = IN_FRAME;
            IN_FRAME: if (w_fall) w_next_state = WAIT_SOF;
        endcase
    end

    always_comb begin
        w_acc_load = 1'b0;
        w_acc_inc  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            WAIT_SOF: w_acc_load = w_rise;
            IN_FRAME: begin
                if (w_fall) w_capture = 1'b1;
                else        w_acc_inc = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed       <= 1'b0;
            r_arm1        <= 1'b0;
            r_arm2        <= 1'b0;
            r_vs_eff_d    <= 1'b0;
            r_acc         <= '0;
            r_diff_count  <= '0;
            r_motion_flag <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_armed      <= r_armed | ~i_vsync_in;
            r_arm1       <= r_armed;
            r_arm2       <= r_arm1;
            r_vs_eff_d   <= w_vs_eff;
            r_frame_done <= w_capture;
            // The first pixel of a frame can share its cycle with the vsync rise.
            if (w_acc_load) begin
                r_acc <= CNT_W'(i_bit2);
            end else if (w_acc_inc && i_bit2 && (r_acc != '1)) begin
                r_acc <= r_acc + CNT_W'(1);
            end
            if (w_capture) begin
                r_diff_count  <= r_acc;
                r_motion_flag <= (r_acc > MOTION_MIN);
            end
        end
    end

    assign o_diff_count  = r_diff_count;
    assign o_motion_flag = r_motion_flag;
    assign o_frame_done  = r_frame_done;

endmodule

// File: rtl/frame_diff_binarize.sv
// Frame-difference motion binarizer: |cur - pre| > per-frame threshold, 3-cycle
// pipeline with sync pass-through. Statistics are built only with FRAME_DIFF_STATS_EN.
module frame_diff_binarize
    import frame_diff_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MOTION_MIN = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Frame_Threshold,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_Y_cur,
    input  logic [DATA_W-1:0] per_img_Y_pre,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic              post_img_Bit,
    output logic [CNT_W-1:0]  diff_count,
    output logic              motion_flag,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] MOTION_MIN_C = CNT_W'(MOTION_MIN);

    sync_t             w_sync_in;
    sync_t             r_sync [PIPE_LAT];
    logic [DATA_W-1:0] w_diff;
    logic              w_vs_rise;
    logic [DATA_W-1:0] r_thr_q;
    logic [DATA_W-1:0] r_diff_s1;
    logic              r_bit_s2;
    logic              r_bit_s3;

    assign w_sync_in = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};
    assign w_diff    = (per_img_Y_cur >= per_img_Y_pre) ? (per_img_Y_cur - per_img_Y_pre)
                                                        : (per_img_Y_pre - per_img_Y_cur);
    assign w_vs_rise = per_frame_vsync & ~r_sync[0].vsync;

    // NOTE: non-blocking updates mean S2 still compares against the old thr_q on
    // the cycle the new one is latched, so in-flight pixels keep their frame's threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thr_q   <= '0;
            r_diff_s1 <= '0;
            r_bit_s2  <= 1'b0;
            r_bit_s3  <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) r_sync[i] <= '0;
        end else begin
            if (w_vs_rise) r_thr_q <= Frame_Threshold;
            r_diff_s1 <= w_diff;
            r_bit_s2  <= (r_diff_s1 > r_thr_q) & r_sync[0].clken;
            r_bit_s3  <= r_bit_s2;
            r_sync[0] <= w_sync_in;
            for (int i = 1; i < PIPE_LAT; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign post_frame_vsync = r_sync[PIPE_LAT-1].vsync;
    assign post_frame_href  = r_sync[PIPE_LAT-1].href;
    assign post_frame_clken = r_sync[PIPE_LAT-1].clken;
    assign post_img_Bit     = r_bit_s3;

`ifdef FRAME_DIFF_STATS_EN
    frame_diff_stats #(
        .CNT_W      (CNT_W),
        .MOTION_MIN (MOTION_MIN_C)
    ) u_stats (
        .clk           (clk),
        .rst           (rst),
        .i_vsync_in    (per_frame_vsync),
        .i_vs2         (r_sync[1].vsync),
        .i_bit2        (r_bit_s2),
        .o_diff_count  (diff_count),
        .o_motion_flag (motion_flag),
        .o_frame_done  (frame_done)
    );
`else
    assign diff_count  = '0;
    // A zero count never exceeds an unsigned threshold, so this is constant 0.
    assign motion_flag = (diff_count > MOTION_MIN_C);
    assign frame_done  = 1'b0;
`endif

endmodule

// File: tb/tb_frame_diff_binarize.sv
// Self-checking bench for frame_diff_binarize: directed frames plus random
// frames, compared every cycle against a frame-level reference model.
module tb_frame_diff_binarize;

`ifdef FRAME_DIFF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int W_A = 20, MIN_A = 5;
    localparam int W_B = 20, MIN_B = 10;
    localparam int W_C = 4,  MIN_C = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] frame_thr = 8'd0;
    logic       tb_vs = 1'b0, tb_hs = 1'b0, tb_ce = 1'b0;
    logic [7:0] tb_cur = 8'd0, tb_pre = 8'd0;

    logic           vs_a, hs_a, ce_a, bit_a, mf_a, done_a;
    logic           vs_b, hs_b, ce_b, bit_b, mf_b, done_b;
    logic           vs_c, hs_c, ce_c, bit_c, mf_c, done_c;
    logic [W_A-1:0] dc_a;
    logic [W_B-1:0] dc_b;
    logic [W_C-1:0] dc_c;

    frame_diff_binarize #(.DATA_W(8), .CNT_W(W_A), .MOTION_MIN(MIN_A)) u_dut_a (
        .clk(clk), .rst(rst), .Frame_Threshold(frame_thr),
        .per_frame_vsync(tb_vs), .per_frame_href(tb_hs), .per_frame_clken(tb_ce),
        .per_img_Y_cur(tb_cur), .per_img_Y_pre(tb_pre),
        .post_frame_vsync(vs_a), .post_frame_href(hs_a), .post_frame_clken(ce_a),
        .post_img_Bit(bit_a), .diff_count(dc_a), .motion_flag(mf_a), .frame_done(done_a));

    frame_diff_binarize #(.DATA_W(8), .CNT_W(W_B), .MOTION_MIN(MIN_B)) u_dut_b (
        .clk(clk), .rst(rst), .Frame_Threshold(frame_thr),
        .per_frame_vsync(tb_vs), .per_frame_href(tb_hs), .per_frame_clken(tb_ce),
        .per_img_Y_cur(tb_cur), .per_img_Y_pre(tb_pre),
        .post_frame_vsync(vs_b), .post_frame_href(hs_b), .post_frame_clken(ce_b),
        .post_img_Bit(bit_b), .diff_count(dc_b), .motion_flag(mf_b), .frame_done(done_b));

    frame_diff_binarize #(.DATA_W(8), .CNT_W(W_C), .MOTION_MIN(MIN_C)) u_dut_c (
        .clk(clk), .rst(rst), .Frame_Threshold(frame_thr),
        .per_frame_vsync(tb_vs), .per_frame_href(tb_hs), .per_frame_clken(tb_ce),
        .per_img_Y_cur(tb_cur), .per_img_Y_pre(tb_pre),
        .post_frame_vsync(vs_c), .post_frame_href(hs_c), .post_frame_clken(ce_c),
        .post_img_Bit(bit_c), .diff_count(dc_c), .motion_flag(mf_c), .frame_done(done_c));

    always #5 clk = ~clk;

    // Expected output for one input cycle, visible three edges later.
    typedef struct {
        bit b;
        bit vs;
        bit hs;
        bit ce;
        bit done;
        int dc;
    } exp_t;

    exp_t sr [3];
    int   m_thr;
    bit   m_prev_vs, m_armed, m_in_frame;
    int   m_cnt, m_dc;
    int   n_pass = 0, n_fail = 0, n_total = 0;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) sr[i] = '{default: 0};
        m_thr = 0; m_prev_vs = 0; m_armed = 0; m_in_frame = 0; m_cnt = 0; m_dc = 0;
    endtask

    task automatic step(input bit v, input bit h, input bit c,
                        input logic [7:0] y_cur, input logic [7:0] y_pre);
        exp_t e;
        int   d, xa, xb, xc;
        tb_vs = v; tb_hs = h; tb_ce = c; tb_cur = y_cur; tb_pre = y_pre;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (v && !m_prev_vs) m_thr = int'(frame_thr);
            d = (y_cur > y_pre) ? int'(y_cur) - int'(y_pre) : int'(y_pre) - int'(y_cur);
            e.b = c && (d > m_thr);
            e.vs = v; e.hs = h; e.ce = c; e.done = 0;
            if (v && !m_prev_vs && m_armed) begin
                m_in_frame = 1; m_cnt = e.b ? 1 : 0;
            end else if (m_in_frame && v) begin
                m_cnt += e.b ? 1 : 0;
            end else if (m_in_frame && !v) begin
                m_in_frame = 0; m_dc = m_cnt; e.done = 1;
            end
            e.dc = m_dc;
            if (!v) m_armed = 1;
            m_prev_vs = v;
            sr[2] = sr[1]; sr[1] = sr[0]; sr[0] = e;
        end
        #1;
        xa = STATS ? sat(sr[2].dc, W_A) : 0;
        xb = STATS ? sat(sr[2].dc, W_B) : 0;
        xc = STATS ? sat(sr[2].dc, W_C) : 0;
        check("post_img_Bit_a",   32'(bit_a), 32'(sr[2].b));
        check("post_img_Bit_b",   32'(bit_b), 32'(sr[2].b));
        check("post_img_Bit_c",   32'(bit_c), 32'(sr[2].b));
        check("post_frame_vsync", 32'(vs_a),  32'(sr[2].vs));
        check("post_frame_href",  32'(hs_a),  32'(sr[2].hs));
        check("post_frame_clken", 32'(ce_a),  32'(sr[2].ce));
        check("diff_count_a",     32'(dc_a),  32'(xa));
        check("diff_count_b",     32'(dc_b),  32'(xb));
        check("diff_count_c",     32'(dc_c),  32'(xc));
        check("motion_flag_a",    32'(mf_a),  32'(xa > MIN_A));
        check("motion_flag_b",    32'(mf_b),  32'(xb > MIN_B));
        check("motion_flag_c",    32'(mf_c),  32'(xc > MIN_C));
        check("frame_done_a",     32'(done_a), 32'(STATS && sr[2].done));
        check("frame_done_b",     32'(done_b), 32'(STATS && sr[2].done));
        check("frame_done_c",     32'(done_c), 32'(STATS && sr[2].done));
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 8'd0, 8'd0);
    endtask

    // Lines of pixels with a blank cycle after each; first nchg pixels differ by 30.
    task automatic frame(input int lines, input int width, input int nchg,
                         input int gap, input bit rnd);
        int p;
        p = 0;
        step(1, 0, 0, 8'd0, 8'd0);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < width; x++) begin
                if (rnd) begin
                    if ($urandom_range(0, 15) == 0) frame_thr = 8'($urandom);
                    step(1, 1, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
                end else if (p < nchg) begin
                    step(1, 1, 1, 8'd100, 8'd70);
                end else begin
                    step(1, 1, 1, 8'd100, 8'd100);
                end
                p++;
            end
            step(1, 0, 0, 8'd0, 8'd0);
        end
        idle(gap);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) step(1, 1, 1, 8'($urandom), 8'($urandom));
        rst = 1'b0;
        idle(2);

        // Threshold 20: diff 15 stays clear, diff 21 flags.
        frame_thr = 8'd20;
        step(1, 0, 0, 8'd0, 8'd0);
        step(1, 1, 1, 8'd100, 8'd85);
        step(1, 1, 1, 8'd100, 8'd121);
        step(1, 0, 0, 8'd0, 8'd0);
        idle(4);

        // Threshold 0 flags any nonzero diff.
        frame_thr = 8'd0;
        step(1, 0, 0, 8'd0, 8'd0);
        step(1, 1, 1, 8'd50, 8'd50);
        step(1, 1, 1, 8'd51, 8'd50);
        step(1, 1, 0, 8'd51, 8'd50);
        idle(4);

        // Threshold 255 never flags.
        frame_thr = 8'd255;
        step(1, 0, 0, 8'd0, 8'd0);
        step(1, 1, 1, 8'd255, 8'd0);
        step(1, 1, 1, 8'd0, 8'd255);
        idle(4);

        // Mid-frame threshold change only lands at the next vsync rise.
        frame_thr = 8'd20;
        step(1, 0, 0, 8'd0, 8'd0);
        repeat (3) step(1, 1, 1, 8'd140, 8'd100);
        frame_thr = 8'd60;
        repeat (4) step(1, 1, 1, 8'd100, 8'd140);
        idle(3);
        step(1, 0, 0, 8'd0, 8'd0);
        repeat (4) step(1, 1, 1, 8'd140, 8'd100);
        idle(4);

        // Pixels outside vsync flow through but are not counted.
        frame_thr = 8'd20;
        repeat (4) step(0, 1, 1, 8'd200, 8'd10);
        idle(3);

        // 8x8 frame with 10 changed pixels, then 20 changed (saturates the 4-bit counter).
        frame(8, 8, 10, 4, 0);
        frame(8, 8, 20, 4, 0);

        // Reset in the middle of a frame drops it; the next full frame counts.
        step(1, 0, 0, 8'd0, 8'd0);
        repeat (5) step(1, 1, 1, 8'd100, 8'd70);
        rst = 1'b1;
        step(1, 1, 1, 8'd100, 8'd70);
        rst = 1'b0;
        repeat (6) step(1, 1, 1, 8'd100, 8'd70);
        idle(4);
        frame(8, 8, 12, 4, 0);

        // Back-to-back frames separated by a single low vsync cycle.
        frame(4, 6, 7, 1, 0);
        frame(4, 6, 3, 1, 0);
        frame(4, 6, 9, 4, 0);

        // Random pixels, clken gaps and threshold changes.
        for (int f = 0; f < 6; f++) begin
            frame_thr = 8'($urandom);
            frame($urandom_range(4, 12), $urandom_range(8, 24), 0, $urandom_range(1, 5), 1);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_diff_binarize.md
Name: frame_diff_binarize

Overview:
- Downstream consumer of the threshold adjust stage.
- Takes the current-frame luma and the previous-frame luma from the frame buffer, computes the absolute difference per pixel, and compares it against Frame_Threshold to produce a 1-bit motion mask.
- Carries the video sync signals through the same pipeline.
- Latches the threshold once per frame so that key presses cannot tear a frame.
- Counts changed pixels per frame and raises a motion flag for the display/alarm logic.

Parameters:
- DATA_W, 8, luma and threshold width.
- CNT_W, 20, changed-pixel counter width (covers 640x480).
- MOTION_MIN, 1000, changed-pixel count a frame must exceed to assert motion_flag.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- Frame_Threshold  in  DATA_W  threshold from the adjust stage; asynchronous to the frame timing
- per_frame_vsync  in  1  high for the whole active frame
- per_frame_href  in  1  high during an active line
- per_frame_clken  in  1  pixel valid strobe
- per_img_Y_cur  in  DATA_W  current-frame luma
- per_img_Y_pre  in  DATA_W  previous-frame luma, aligned with per_img_Y_cur
- post_frame_vsync  out  1  vsync delayed 3 cycles
- post_frame_href  out  1  href delayed 3 cycles
- post_frame_clken  out  1  clken delayed 3 cycles
- post_img_Bit  out  1  1 = pixel changed
- diff_count  out  CNT_W  changed-pixel count of the last completed frame
- motion_flag  out  1  diff_count > MOTION_MIN for the last completed frame
- frame_done  out  1  one-cycle pulse when diff_count/motion_flag update

Behaviour:
- Reset (rst high at a clk edge): every output is 0; the latched threshold is 0; all pipeline registers, the accumulator and the FSM are cleared to WAIT_SOF. Reset mid-frame drops the frame: no frame_done, diff_count is 0.
- Threshold latch:
  - thr_q <= Frame_Threshold in the cycle a rising edge of per_frame_vsync is detected (registered vsync 0, input 1).
  - thr_q is held for the whole frame; Frame_Threshold changes mid-frame take effect at the next frame.
- Pipeline, fixed 3-cycle latency for data and syncs:
  - S1: diff = |cur - pre|, computed unsigned over DATA_W bits, no overflow possible; the sync signals are registered alongside.
  - S2: bit = (diff > thr_q) & clken_s1. The compare is strict: threshold 0 flags any nonzero diff; threshold 255 never flags.
  - S3: post_img_Bit and the post_* sync outputs are registered.
  - post_img_Bit is 0 whenever post_frame_clken is 0.
- FSM, driven by vsync at S2 (vs2):
  - WAIT_SOF: on a vs2 rising edge, clear the accumulator and go to IN_FRAME.
  - IN_FRAME: accumulator += bit_s2. The accumulator saturates at all-ones and never wraps.
  - IN_FRAME: on a vs2 falling edge, diff_count <= accumulator (including the final pixel in S2 that cycle); motion_flag <= (accumulator > MOTION_MIN); frame_done = 1 for the next single cycle; go to WAIT_SOF.
  - A frame whose vsync rising edge falls before reset release is ignored until the next rising edge.
- clken without vsync high is passed through the pipeline but not counted.
- Back-to-back frames with one low vsync cycle are supported: the falling and rising edges are handled on consecutive cycles without losing counts.

Optional Feature:
- Macro FRAME_DIFF_STATS_EN.
- Defined: the accumulator, FSM, diff_count, motion_flag and frame_done are implemented as described above.
- Undefined: the statistics logic is not built; diff_count, motion_flag and frame_done are tied to 0. The pipeline and threshold latch are unchanged.

Decomposition:
- Shared package frame_diff_pkg holds:
  - DATA_W and CNT_W defaults;
  - the FSM state encoding (WAIT_SOF = 0, IN_FRAME = 1);
  - the pipeline latency constant (3), shared with the sync-delay logic of neighbouring stages.
- One natural sub-module, frame_diff_stats: the accumulator, FSM and output registers, instantiated only under FRAME_DIFF_STATS_EN.

Test Plan:
- Threshold 20, cur=100/pre=85 then cur=100/pre=121 -> post_img_Bit 0 then 1, each exactly 3 cycles after its clken; syncs also delayed 3 cycles.
- Boundaries: threshold 0 with cur=pre=50 -> 0; cur=51 -> 1; threshold 255 with cur=255, pre=0 -> 0.
- Frame_Threshold changed from 20 to 60 mid-frame, diff=40 pixels -> 1 for the rest of that frame, 0 from the next vsync rise.
- 8x8 frame with 10 pixels differing by 30 at threshold 20, MOTION_MIN=5 -> frame_done one cycle after the S2 vsync fall, diff_count=10, motion_flag=1. Repeat with MOTION_MIN=10 -> motion_flag=0.
- rst pulsed mid-frame -> all outputs 0 next cycle, no frame_done for that frame; the next full frame counts correctly.
- Build without FRAME_DIFF_STATS_EN, same frame -> identical post_img_Bit stream; diff_count, motion_flag and frame_done stay 0.
